// File: rtl/led_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_ctrl
// Description : Frame controller for a WS2812-style serial LED driver.
//               Pixel bytes land in a shadow buffer through a valid/ready
//               write port. A commit scales every byte by a global
//               brightness (one byte per cycle) into a staging buffer. The
//               staged frame is then copied to data_o in one cycle, but only
//               while the driver sits in its refresh gap, so a frame is
//               never torn mid-transmission.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               wr_valid/wr_ready - pixel-byte write handshake
//               wr_idx, wr_chan   - LED index and channel (G,R,B) of write
//               wr_data           - channel value
//               brightness        - global scale, sampled at commit start
//               commit_req        - single-cycle commit request pulse
//               commit_busy       - commit running or pending
//               commit_done       - one-cycle pulse aligned with new data_o
//               drv_idle          - driver is in its refresh state
//               data_o            - bit-reversed frame bus to the driver
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_ctrl #(
  parameter  int LED_CNT       = 3,
  parameter  int CHANNELS      = 3,
  parameter  int BITPERCHANNEL = 8,
  localparam int IDX_W         = (LED_CNT > 1) ? $clog2(LED_CNT) : 1,
  localparam int DW            = LED_CNT * CHANNELS * BITPERCHANNEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [1:0]         wr_chan,
  input  logic [7:0]         wr_data,
  input  logic [7:0]         brightness,
  input  logic               commit_req,
  output logic               commit_busy,
  output logic               commit_done,
  input  logic               drv_idle,
  output logic [DW-1:0]      data_o
);

  localparam int BW    = BITPERCHANNEL;
  localparam int PW    = 2 * BW;
  localparam int N     = LED_CNT * CHANNELS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCALE    = 2'd1,
    WAIT_WIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start;
  logic               w_scale_en;
  logic               w_load;

  logic [BW-1:0]      r_shadow [N];
  logic [BW-1:0]      r_staged [N];
  logic [DW-1:0]      r_data;
  logic [BW-1:0]      r_bscale;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pending;
  logic               r_done;
  logic [BW-1:0]      w_scaled;
  logic               w_wr_fire;

  // Multiplying by (bscale+1) and keeping the top byte makes 255 an exact
  // identity and lets 0 still dim full-scale values down to 0.
  assign w_scaled = BW'((PW'(r_shadow[r_cnt]) * (PW'(r_bscale) + PW'(1))) >> BW);

  assign wr_ready    = (r_state != SCALE);
  assign w_wr_fire   = wr_valid && wr_ready;
  assign commit_busy = (r_state != IDLE) || r_pending;
  assign commit_done = r_done;
  assign data_o      = r_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_scale_en  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (commit_req || r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = SCALE;
        end
      end
      SCALE: begin
        w_scale_en = 1'b1;
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_nxt = WAIT_WIN;
        end
      end
      WAIT_WIN: begin
        if (drv_idle) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: shadow writes, scaling, frame load, pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= '0;
        r_staged[k] <= '0;
      end
      r_data    <= '0;
      r_bscale  <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_load;

      // Out-of-range index/channel match no slot, so such a write completes
      // its handshake and is silently dropped.
      if (w_wr_fire) begin
        for (int i = 0; i < LED_CNT; i++) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (wr_idx == IDX_W'(i) && wr_chan == 2'(c)) begin
              r_shadow[i*CHANNELS + c] <= wr_data;
            end
          end
        end
      end

      if (w_start) begin
        r_bscale <= brightness;
        r_cnt    <= '0;
      end else if (w_scale_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // One-deep request memory; a start consumes it together with any
      // request arriving in the same IDLE cycle.
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (commit_req && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end

      if (w_scale_en) begin
        r_staged[r_cnt] <= w_scaled;
      end

      // The driver shifts out bit 0 first while LEDs expect MSB first, so
      // each byte is placed bit-reversed on the bus.
      if (w_load) begin
        for (int k = 0; k < N; k++) begin
          for (int j = 0; j < BW; j++) begin
            r_data[k*BW + j] <= r_staged[k][BW-1-j];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_frame_ctrl
// Description : Directed self-checking bench for led_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_frame_ctrl;

  localparam int DW = 72;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_idx;
  logic [1:0]    wr_chan;
  logic [7:0]    wr_data;
  logic [7:0]    brightness;
  logic          commit_req;
  logic          commit_busy;
  logic          commit_done;
  logic          drv_idle;
  logic [DW-1:0] data_o;

  int errors = 0;
  int checks = 0;

  led_frame_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .brightness  (brightness),
    .commit_req  (commit_req),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .drv_idle    (drv_idle),
    .data_o      (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns the number of cycles wr_ready was low before acceptance.
  task automatic wr(input logic [1:0] idx, input logic [1:0] chan,
                    input logic [7:0] val, output int stall);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_chan  = chan;
    wr_data  = val;
    stall    = 0;
    while (!wr_ready && stall < 100) begin
      tick();
      stall++;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  // Cycles from the commit_req cycle T until commit_done is seen.
  task automatic commit_lat(output int lat);
    pulse_commit();
    lat = 1;
    while (!commit_done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int stall;
    int lat;
    int pulses;
    reset      = 1'b0;
    wr_valid   = 1'b0;
    wr_idx     = '0;
    wr_chan    = '0;
    wr_data    = '0;
    brightness = 8'd255;
    commit_req = 1'b0;
    drv_idle   = 1'b1;

    do_reset();
    chk("rst_data",  data_o, '0);
    chk("rst_ready", DW'(wr_ready), DW'(1));
    chk("rst_busy",  DW'(commit_busy), DW'(0));
    chk("rst_done",  DW'(commit_done), DW'(0));

    // Identity brightness, bit reversal per byte
    wr(2'd0, 2'd0, 8'hFF, stall);
    wr(2'd0, 2'd1, 8'h01, stall);
    wr(2'd0, 2'd2, 8'h80, stall);
    brightness = 8'd255;
    commit_lat(lat);
    chk("t1_latency", DW'(lat), DW'(11));
    chk("t1_data", data_o, 72'h00_0000_0000_0001_80FF);
    tick();
    chk("t1_done_1cyc", DW'(commit_done), DW'(0));
    chk("t1_busy_end",  DW'(commit_busy), DW'(0));

    // 200 * 128 >> 8 = 100 -> 0x64 reversed 0x26; 0x80*128>>8=0x40 -> 0x02
    wr(2'd0, 2'd0, 8'd200, stall);
    brightness = 8'd127;
    commit_lat(lat);
    chk("t2_data", data_o, 72'h00_0000_0000_0002_0026);

    // brightness 0 maps 255 to 0
    wr(2'd0, 2'd0, 8'hFF, stall);
    brightness = 8'd0;
    commit_lat(lat);
    chk("t3_data", data_o, '0);
    tick();

    // Commit held off by a busy driver for 50 cycles
    wr(2'd0, 2'd0, 8'h0F, stall);
    brightness = 8'd255;
    drv_idle   = 1'b0;
    pulse_commit();
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      chk("t4_hold_data", data_o, '0);
      chk("t4_hold_busy", DW'(commit_busy), DW'(1));
      if (commit_done) pulses++;
      tick();
    end
    drv_idle = 1'b1;
    tick();
    chk("t4_done_rise", DW'(commit_done), DW'(1));
    chk("t4_data", data_o, 72'h00_0000_0000_0001_80F0);
    if (commit_done) pulses++;
    tick();
    if (commit_done) pulses++;
    chk("t4_pulses", DW'(pulses), DW'(1));

    // Write held across SCALE; lands in WAIT_WIN so misses this commit
    pulse_commit();
    wr(2'd2, 2'd2, 8'h55, stall);
    chk("t5_stall", DW'(stall), DW'(9));
    lat = 0;
    while (!commit_done && lat < 50) begin
      tick();
      lat++;
    end
    chk("t5_done", DW'(commit_done), DW'(1));
    chk("t5_excluded", DW'(data_o[71:64]), DW'(8'h00));
    tick();
    commit_lat(lat);
    chk("t5_included", DW'(data_o[71:64]), DW'(8'hAA));

    // Out-of-range writes complete but are dropped
    do_reset();
    wr(2'd3, 2'd0, 8'hFF, stall);
    chk("t6_hs_idx", DW'(stall), DW'(0));
    wr(2'd0, 2'd3, 8'hFF, stall);
    chk("t6_hs_chan", DW'(stall), DW'(0));
    commit_lat(lat);
    chk("t6_done", DW'(commit_done), DW'(1));
    chk("t6_data", data_o, '0);
    tick();

    // Two requests during SCALE merge into one extra commit
    wr(2'd1, 2'd1, 8'h12, stall);
    brightness = 8'd255;
    pulse_commit();
    pulses = 0;
    tick();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (commit_done) pulses++;
      tick();
    end
    chk("t7_pulses", DW'(pulses), DW'(2));
    chk("t7_busy_end", DW'(commit_busy), DW'(0));
    chk("t7_data", DW'(data_o[39:32]), DW'(8'h48));

    // Reset while waiting for the refresh window
    drv_idle = 1'b0;
    wr(2'd2, 2'd0, 8'hC3, stall);
    pulse_commit();
    for (int i = 0; i < 12; i++) tick();
    chk("t8_busy_wait", DW'(commit_busy), DW'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t8_data", data_o, '0);
    chk("t8_busy", DW'(commit_busy), DW'(0));
    drv_idle = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (commit_done) pulses++;
      tick();
    end
    chk("t8_no_done", DW'(pulses), DW'(0));
    chk("t8_data_end", data_o, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_frame_ctrl.md
Name: led_frame_ctrl

Overview:
- Frame controller that feeds the parallel `data` bus of the WS2812-style serial LED driver.
- Pixel bytes are written into a shadow buffer through a valid/ready port.
- On a commit request, the block scales every byte by a global brightness (one byte per cycle) into a staging buffer.
- The staged frame is copied to `data_o` in a single cycle, only while the driver is in its refresh gap, so a frame is never torn mid-transmission.

Parameters:
- LED_CNT, 3, number of LEDs in the chain.
- CHANNELS, 3, colour channels per LED (order G,R,B as sent on the wire).
- BITPERCHANNEL, 8, bits per channel; the block supports only 8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  pixel-byte write request
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- wr_idx  input  max(1,$clog2(LED_CNT))  LED index
- wr_chan  input  2  channel index
- wr_data  input  8  channel value
- brightness  input  8  global scale, sampled at commit start
- commit_req  input  1  single-cycle pulse requesting a frame commit
- commit_busy  output  1  commit in progress or pending
- commit_done  output  1  single-cycle pulse when `data_o` has been updated
- drv_idle  input  1  high while the driver is in its refresh state
- data_o  output  LED_CNT*CHANNELS*8  frame bus to the driver `data` input

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - All buffers, data_o, commit_done, the pending flag and the byte counter clear to 0.
  - State returns to IDLE; wr_ready=1 from the first cycle after reset.
  - Reset mid-commit aborts the commit; data_o returns to 0.
- Byte k = idx*CHANNELS+chan, with N = LED_CNT*CHANNELS bytes in total.
  - The driver sends data bit 0 first and the LEDs expect MSB first.
  - Therefore value bit 7-j sits at data_o[k*8+j] (bit-reversed within each byte).
- Writes:
  - A write is accepted when wr_valid && wr_ready and stores wr_data into shadow[k] at the clock edge.
  - If wr_idx>=LED_CNT or wr_chan>=CHANNELS, the write is accepted (handshake completes) but discarded.
- wr_ready = (state != SCALE), driven combinationally from the registered state.
- FSM:
  - IDLE: on commit_req or pending=1, latch brightness into bscale, clear pending, set cnt=0, go to SCALE.
  - SCALE: one byte per cycle, staged[cnt] = (shadow[cnt] * (bscale+1)) >> 8, using a 16-bit product with the top 8 bits kept.
    - brightness=255 gives identity; brightness=0 maps 255 to 0.
    - When cnt==N-1, go to WAIT_WIN.
  - WAIT_WIN: in the first cycle with drv_idle=1, load data_o from staged (bit-reversed) and go to IDLE.
    - commit_done pulses for exactly one cycle, aligned with the new data_o.
- Latency: commit_req at cycle T in IDLE with drv_idle held high gives data_o updated and commit_done=1 at T+N+2.
- Writes and commit_req together:
  - A write and commit_req in the same IDLE cycle: the write is included in the commit.
  - Writes during WAIT_WIN land in shadow only and are excluded from this commit.
- commit_req arriving while not in IDLE sets pending (one deep; further requests merge).
  - The pending commit starts on the cycle after commit_done.
- commit_busy = (state != IDLE) || pending.
- Driver contract: drv_idle deasserts at least 2 cycles before the driver starts sampling data. The controller never changes data_o while drv_idle=0.

Test Plan:
- After reset, write LED0 G=0xFF, R=0x01, B=0x80 with brightness=255, then commit with drv_idle=1.
  - Required: commit_done at T+11; data_o[7:0]=0xFF, [15:8]=0x80 (0x01 reversed), [23:16]=0x01 (0x80 reversed); all other bits 0.
- Shadow byte 200 with brightness=127, commit.
  - Required: staged value 100, i.e. data_o byte 0x26 (0x64 reversed).
- Shadow byte 255 with brightness=0, commit.
  - Required: data_o byte = 0x00.
- Commit with drv_idle=0 for 50 cycles, then 1.
  - Required: data_o unchanged throughout; commit_done exactly once, one cycle after drv_idle rises.
  - Required: commit_busy=1 for the whole wait.
- Hold wr_valid during SCALE.
  - Required: wr_ready=0 for the 9 SCALE cycles, then the write completes.
- Write idx=3, chan=0, then commit.
  - Required: handshake completes; data_o stays all-zero.
- Two commit_req pulses during SCALE.
  - Required: exactly one further commit runs, giving 2 commit_done pulses in total.
- Assert reset in WAIT_WIN.
  - Required: data_o=0, commit_busy=0, no commit_done.
